// File: rtl/sprite_line_eval_pkg.sv
// Shared OAM entry, sprite slot and scan-state types for the sprite engine.
// MAX_SPRITES_PER_LINE sets the number of per-line sprite slots (default 8).
`ifndef MAX_SPRITES_PER_LINE
`define MAX_SPRITES_PER_LINE 8
`endif

package sprite_line_eval_pkg;

    localparam int OAM_ENTRIES = 64;
    localparam int OAM_AW      = $clog2(OAM_ENTRIES);

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] tile;
        logic [3:0] palette;
        logic [1:0] size;
        logic       fg_prio;
        logic       bg_prio;
    } oam_entry_t;

    typedef struct packed {
        logic [OAM_AW-1:0] index;
        logic [5:0]        y_off;
    } sprite_slot_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_FIN
    } scan_state_t;

endpackage

// File: rtl/sprite_line_eval_row_hit.sv
// sprite_row_hit: combinational row/sprite intersection test with wrapping rows.
// Height is 8 << size; also used by the sprite units.
module sprite_row_hit (
    input  logic [7:0] i_row,
    input  logic [7:0] i_y,
    input  logic [1:0] i_size,
    output logic       o_hit,
    output logic [7:0] o_y_off
);

    logic [8:0] w_height;

    assign o_y_off  = i_row - i_y;
    assign w_height = 9'd8 << i_size;
    assign o_hit    = {1'b0, o_y_off} < w_height;

endmodule

// File: rtl/sprite_line_eval.sv
// sprite_line_eval: scans OAM in horizontal blank and fills per-line sprite slots.
// Define SPRITE_OVERFLOW_EN for full scans with overflow; otherwise scans stop when slots fill.
`ifndef MAX_SPRITES_PER_LINE
`define MAX_SPRITES_PER_LINE 8
`endif

module sprite_line_eval #(
    parameter  int SPRITES     = `MAX_SPRITES_PER_LINE,
    parameter  int OAM_ENTRIES = sprite_line_eval_pkg::OAM_ENTRIES,
    localparam int AW          = $clog2(OAM_ENTRIES),
    localparam int IW          = $clog2(SPRITES),
    localparam int CW          = IW + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [7:0]                         row,
    output logic [AW-1:0]                      oam_addr,
    input  sprite_line_eval_pkg::oam_entry_t   oam_data,
    output logic                               slot_we,
    output logic [IW-1:0]                      slot_idx,
    output sprite_line_eval_pkg::sprite_slot_t slot_data,
    output logic [CW-1:0]                      slot_count,
    output logic                               busy,
    output logic                               done,
    output logic                               overflow
);

    localparam logic [AW-1:0] LAST = AW'(OAM_ENTRIES - 1);

    sprite_line_eval_pkg::scan_state_t r_state, w_next;
    sprite_line_eval_pkg::sprite_slot_t w_slot;

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_idx;
    logic          r_vld;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [7:0]    r_row;
    logic          w_chk;
    logic          w_hit;
    logic [7:0]    w_yoff;
    logic          w_we;
    logic          w_ovf_set;
    logic          w_stop;
    logic          w_unused;

    sprite_row_hit u_hit (
        .i_row   (r_row),
        .i_y     (oam_data.y),
        .i_size  (oam_data.size),
        .o_hit   (w_hit),
        .o_y_off (w_yoff)
    );

    assign w_unused = ^{oam_data.x, oam_data.tile, oam_data.palette,
                        oam_data.fg_prio, oam_data.bg_prio, w_yoff[7:6]};

    assign w_chk = r_vld && (r_state == sprite_line_eval_pkg::S_SCAN ||
                             r_state == sprite_line_eval_pkg::S_DRAIN);
    // A restart discards the check in flight this cycle
    assign w_we  = w_chk && w_hit && !start && (r_count < CW'(SPRITES));

`ifdef SPRITE_OVERFLOW_EN
    assign w_ovf_set = w_chk && w_hit && !start && (r_count == CW'(SPRITES));
    assign w_stop    = 1'b0;
`else
    assign w_ovf_set = 1'b0;
    assign w_stop    = w_we && (r_count == CW'(SPRITES - 1));
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            sprite_line_eval_pkg::S_IDLE: begin
                if (start) w_next = sprite_line_eval_pkg::S_SCAN;
            end
            sprite_line_eval_pkg::S_SCAN: begin
                if (start)            w_next = sprite_line_eval_pkg::S_SCAN;
                else if (w_stop)      w_next = sprite_line_eval_pkg::S_FIN;
                else if (r_addr == LAST) w_next = sprite_line_eval_pkg::S_DRAIN;
            end
            sprite_line_eval_pkg::S_DRAIN: begin
                w_next = start ? sprite_line_eval_pkg::S_SCAN
                               : sprite_line_eval_pkg::S_FIN;
            end
            sprite_line_eval_pkg::S_FIN: begin
                w_next = start ? sprite_line_eval_pkg::S_SCAN
                               : sprite_line_eval_pkg::S_IDLE;
            end
            default: w_next = sprite_line_eval_pkg::S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= sprite_line_eval_pkg::S_IDLE;
            r_addr  <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_row   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= r_addr;
            if (start) begin
                r_addr  <= '0;
                r_vld   <= 1'b0;
                r_count <= '0;
                r_ovf   <= 1'b0;
                r_row   <= row;
            end else begin
                r_vld <= (r_state == sprite_line_eval_pkg::S_SCAN);
                if (r_state == sprite_line_eval_pkg::S_SCAN && r_addr != LAST)
                    r_addr <= r_addr + 1'b1;
                if (w_we)      r_count <= r_count + 1'b1;
                if (w_ovf_set) r_ovf   <= 1'b1;
            end
        end
    end

    always_comb begin
        w_slot       = '0;
        w_slot.index = sprite_line_eval_pkg::OAM_AW'(r_idx);
        w_slot.y_off = w_yoff[5:0];
    end

    assign oam_addr   = r_addr;
    assign slot_we    = w_we;
    assign slot_idx   = w_we ? r_count[IW-1:0] : '0;
    assign slot_data  = w_we ? w_slot : '0;
    assign slot_count = r_count;
    assign busy       = (r_state == sprite_line_eval_pkg::S_SCAN) ||
                        (r_state == sprite_line_eval_pkg::S_DRAIN);
    assign done       = (r_state == sprite_line_eval_pkg::S_FIN);
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_sprite_line_eval.sv
// Scoreboard bench for sprite_line_eval: directed OAM images, queued slot writes.
// Expected writes are queued by the stimulus and popped by an independent monitor.
`ifndef MAX_SPRITES_PER_LINE
`define MAX_SPRITES_PER_LINE 8
`endif

module tb_sprite_line_eval;
    import sprite_line_eval_pkg::*;

    localparam int SP = `MAX_SPRITES_PER_LINE;
    localparam int CW = $clog2(SP) + 1;

    typedef struct {
        int idx;
        int slot;
        int yoff;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [7:0]           row;
    logic [5:0]           oam_addr;
    oam_entry_t           oam_data;
    logic                 slot_we;
    logic [$clog2(SP)-1:0] slot_idx;
    sprite_slot_t         slot_data;
    logic [CW-1:0]        slot_count;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    oam_entry_t oam [64];
    exp_t       q[$];
    exp_t       m_e;
    int         checks = 0;
    int         errors = 0;
    int         dones  = 0;
    int         dn;
    int         d0;

    sprite_line_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .row        (row),
        .oam_addr   (oam_addr),
        .oam_data   (oam_data),
        .slot_we    (slot_we),
        .slot_idx   (slot_idx),
        .slot_data  (slot_data),
        .slot_count (slot_count),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) oam_data <= oam[oam_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && slot_we) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got oam %0d expected none",
                         slot_data.index);
            end else begin
                m_e = q.pop_front();
                chk("slot_idx", int'(slot_idx), m_e.slot);
                chk("slot_oam", int'(slot_data.index), m_e.idx);
                chk("slot_yoff", int'(slot_data.y_off), m_e.yoff);
            end
        end
        if (done) dones++;
    end

    task automatic clear_oam();
        for (int i = 0; i < 64; i++) begin
            oam[i]      = '0;
            oam[i].y    = 8'd200;
            oam[i].size = 2'd0;
        end
    endtask

    task automatic set_ent(input int i, input int y, input int sz);
        oam[i].y    = 8'(y);
        oam[i].size = 2'(sz);
    endtask

    task automatic push(input int idx, input int slot, input int yoff);
        exp_t e;
        e.idx  = idx;
        e.slot = slot;
        e.yoff = yoff;
        q.push_back(e);
    endtask

    // n counts cycles after the sampling edge of start; -1 means no done seen
    task automatic scan(input logic [7:0] r, input int rs_at,
                        input logic [7:0] r2, input int rst_at,
                        output int dno);
        dno = -1;
        @(negedge clk);
        start = 1'b1;
        row   = r;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = (n == rs_at);
            if (n == rs_at) row = r2;
            rst_n = !(n == rst_at);
            if (n == 1) begin
                chk("busy_t1", int'(busy), 1);
                chk("addr_t1", int'(oam_addr), 0);
            end
            if (n == 6 && rs_at < 0 && rst_at < 0)
                chk("addr_t6", int'(oam_addr), 5);
            if (rst_at > 0 && n == rst_at + 1) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_addr", int'(oam_addr), 0);
                chk("rst_count", int'(slot_count), 0);
                chk("rst_we", int'(slot_we), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_ovf", int'(overflow), 0);
            end
            if (done) begin
                dno = n;
                chk("busy_at_done", int'(busy), 0);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic settle(input string name, input int ndone);
        repeat (3) @(negedge clk);
        chk({name, "_dones"}, dones - d0, ndone);
        chk({name, "_queue"}, q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        row   = 8'd0;
        clear_oam();
        repeat (3) @(negedge clk);
        chk("reset_addr", int'(oam_addr), 0);
        chk("reset_we", int'(slot_we), 0);
        chk("reset_sidx", int'(slot_idx), 0);
        chk("reset_sdata", int'(slot_data), 0);
        chk("reset_count", int'(slot_count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        clear_oam();
        set_ent(5, 10, 0);
        push(5, 0, 2);
        d0 = dones;
        scan(8'd12, -1, 8'd0, -1, dn);
        chk("single_done_cycle", dn, 66);
        chk("single_count", int'(slot_count), 1);
        chk("single_ovf", int'(overflow), 0);
        settle("single", 1);

        clear_oam();
        set_ent(3, 50, 0);
        set_ent(7, 45, 1);
        set_ent(40, 22, 2);
        push(3, 0, 2);
        push(7, 1, 7);
        push(40, 2, 30);
        d0 = dones;
        scan(8'd52, -1, 8'd0, -1, dn);
        chk("order_done_cycle", dn, 66);
        chk("order_count", int'(slot_count), 3);
        settle("order", 1);

        clear_oam();
        set_ent(9, 250, 1);
        set_ent(10, 250, 0);
        push(9, 0, 9);
        d0 = dones;
        scan(8'd3, -1, 8'd0, -1, dn);
        chk("wrap_done_cycle", dn, 66);
        chk("wrap_count", int'(slot_count), 1);
        settle("wrap", 1);

        clear_oam();
        for (int i = 0; i < SP + 2; i++) set_ent(2 + 2 * i, 100, 0);
        for (int i = 0; i < SP; i++) push(2 + 2 * i, i, 3);
        d0 = dones;
        scan(8'd103, -1, 8'd0, -1, dn);
`ifdef SPRITE_OVERFLOW_EN
        chk("full_done_cycle", dn, 66);
        chk("full_ovf", int'(overflow), 1);
`else
        chk("full_done_cycle", dn, 2 * SP + 3);
        chk("full_ovf", int'(overflow), 0);
`endif
        chk("full_count", int'(slot_count), SP);
        settle("full", 1);

        clear_oam();
        set_ent(3, 50, 0);
        set_ent(7, 45, 1);
        set_ent(40, 22, 2);
        set_ent(9, 250, 1);
        set_ent(10, 250, 0);
        push(3, 0, 2);
        push(7, 1, 7);
        push(9, 0, 9);
        d0 = dones;
        scan(8'd52, 20, 8'd3, -1, dn);
        chk("restart_done_cycle", dn, 86);
        chk("restart_count", int'(slot_count), 1);
        settle("restart", 1);

        clear_oam();
        set_ent(3, 50, 0);
        set_ent(7, 45, 1);
        set_ent(40, 22, 2);
        push(3, 0, 2);
        push(7, 1, 7);
        d0 = dones;
        scan(8'd52, -1, 8'd0, 10, dn);
        chk("reset_mid_no_done", dn, -1);
        chk("reset_mid_count", int'(slot_count), 0);
        settle("reset_mid", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_eval.md
# sprite_line_eval

Scans OAM during horizontal blank, finds the sprites that intersect the next scanline, and writes them in ascending OAM order into the per-line sprite slots that feed the sprite units. Slot index order is the priority order used downstream: slot 0 holds the lowest OAM index and wins ties in the sprite pixel selector. The block sits between the OAM RAM read port and the sprite unit bank inside the sprite engine.

## Interface
- `SPRITES`, default `` `MAX_SPRITES_PER_LINE ``: number of slots.
- `OAM_ENTRIES`, default 64: OAM entries scanned per line.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a scan.
- `row`  in  8  scanline to evaluate; sampled on `start`.
- `oam_addr`  out  $clog2(OAM_ENTRIES)  OAM read address.
- `oam_data`  in  oam_entry_t  OAM read data, valid one cycle after `oam_addr`.
- `slot_we`  out  1  slot write strobe.
- `slot_idx`  out  $clog2(SPRITES)  slot being written.
- `slot_data`  out  sprite_slot_t  {OAM index, y_off[5:0]}.
- `slot_count`  out  $clog2(SPRITES)+1  number of slots filled this line.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when the scan ends.
- `overflow`  out  1  more than SPRITES sprites hit this row.

## Operation
- FSM states:
  - IDLE: `start` → SCAN; clear the count, `overflow` and the address; latch `row`.
  - SCAN: issue `oam_addr` = k on scan cycle k. Data returns one cycle later and is checked in a 1-deep pipeline stage.
  - DRAIN: the last address has been issued; check the final entry, then go to FIN.
  - FIN: pulse `done`, go to IDLE.
- Hit test: `y_off` = (row − entry.y) mod 256, computed 8-bit; height = 8 << entry.size (size 0..3 → 8, 16, 32, 64). A sprite hits when `y_off` < height. Rows wrap, so y = 250 with height 16 hits row 3 (`y_off` = 9).
- On a hit with `slot_count` < SPRITES:
  - `slot_we` = 1, `slot_idx` = `slot_count`, `slot_data` = {index, `y_off`[5:0]}.
  - `slot_count` increments on the next edge.
- A hit with `slot_count` == SPRITES is not written (see Configuration).
- Slots at or above `slot_count` are stale. Consumers must mask with `slot_count`; the block does not clear slot contents.
- `start` in any non-IDLE state restarts the scan from entry 0 with the new `row`. The in-flight check is discarded, and no `done` is produced for the aborted scan.
- Reset values: state IDLE; `oam_addr` 0; `slot_we` 0; `slot_idx` 0; `slot_data` 0; `slot_count` 0; `busy` 0; `done` 0; `overflow` 0.
- `slot_count` and `overflow` hold their values after `done` until the next `start`.

## Timing
- `start` sampled at edge T:
  - `busy` = 1 from T+1.
  - `oam_addr` = k during cycle T+1+k.
  - Entry k's `slot_we` is asserted in cycle T+2+k.
- Full scan: last write opportunity is T+1+OAM_ENTRIES; `done` is high in cycle T+2+OAM_ENTRIES; `busy` falls in that same cycle.
- At most one slot write per cycle. Writes are issued combinationally from the check stage and are registered by the slot bank.

## Configuration
- `SPRITE_OVERFLOW_EN` defined:
  - The scan always covers all OAM_ENTRIES.
  - `overflow` sets on the first hit seen while `slot_count` == SPRITES.
  - `done` timing is fixed, as in Timing.
- `SPRITE_OVERFLOW_EN` undefined:
  - The scan terminates early. The cycle after the write that makes `slot_count` == SPRITES, go to FIN; the in-flight read is discarded.
  - `overflow` is tied to 0.

## Structure
- Sprite package (`sprite_defines.vh`) gains:
  - `oam_entry_t` {x[8:0], y[7:0], tile, palette, size[1:0], fg_prio, bg_prio}.
  - `sprite_slot_t`.
  - `OAM_ENTRIES`.
- One sub-module, `sprite_row_hit`: combinational hit test (row, y, size → hit, `y_off`), shared with the sprite units.

## Test plan
- **Single hit:** OAM[5] y = 10, size 0; `row` = 12; others off-row → one write, `slot_idx` 0, `slot_data` {5, 2}; `slot_count` 1; `done` at T+66.
- **Order:** entries 3, 7 and 40 hit → slots 0, 1 and 2 hold indices 3, 7 and 40, in that order.
- **Wrap:** y = 250, size 1, `row` = 3 → hit with `y_off` 9. With size 0 and `row` = 3 → no hit.
- **Full slots:** SPRITES + 2 hits.
  - With `SPRITE_OVERFLOW_EN`: SPRITES writes, `overflow` = 1, `done` at T+66.
  - Without it: `done` the cycle after the last write, `overflow` = 0.
- **Restart:** `start` again at T+20 with a new `row` → `slot_count` restarts at 0, results match the new `row` only, exactly one `done` (at T+86).
- **Reset:** `rst_n` low mid-scan for one cycle → all outputs at their reset values on the next cycle; no `done`.
